serial_tx: RTL
==============

Name: serial_tx

Overview:
- Parallel-to-serial frame transmitter: the sending end of a simple asynchronous serial link.
- Accepts one DATA_W-bit word per valid/ready handshake.
- Emits a start bit, data LSB first, an optional parity bit and a stop bit, each held for CLKS_PER_BIT clocks.
- Sits between a parallel producer (register/latch stage) and an external single-wire line.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16).
- CLKS_PER_BIT, 16, clock cycles per serial bit (>= 2).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0).

Ports:
- clk  input  1  system clock; one clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- tx_data  input  DATA_W  word to send; sampled only on handshake.
- tx_valid  input  1  producer has a word.
- tx_ready  output  1  block can accept a word this cycle.
- tx_serial  output  1  serial line, idle high.
- tx_busy  output  1  frame in progress (START..STOP).
- tx_done  output  1  one-cycle pulse on the last clock of the stop bit.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state = IDLE, tx_serial = 1, tx_ready = 1, tx_busy = 0, tx_done = 0.
  - Shift register and counters cleared.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_serial = 1, tx_ready = 1.
  - Handshake = tx_valid && tx_ready at a rising edge. On handshake, tx_data is captured into the shift register, parity is computed, and the next state is START.
- START: tx_serial = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx_serial = shift_reg[0]; shift right each CLKS_PER_BIT cycles.
  - After DATA_W bits, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx_serial = XOR of captured data, inverted if PARITY_ODD; lasts CLKS_PER_BIT cycles, then STOP.
- STOP: tx_serial = 1 for CLKS_PER_BIT cycles. tx_done = 1 on the final cycle, then IDLE.
- Outputs are registered: tx_serial changes on the clock edge after the handshake, with no combinational path from inputs.
- tx_ready = 1 only in IDLE; tx_busy = 1 in all other states.
- Latency: handshake edge -> tx_serial falls one cycle later (first START cycle).
- Frame length: (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles.
- Back-to-back words (tx_valid held high): the IDLE accept cycle gives exactly 1 idle-high cycle between the stop bit and the next start bit.
- Mid-frame input rules:
  - tx_data changes while busy are ignored.
  - tx_valid while busy is not accepted and is not stored.
- Reset asserted mid-frame: tx_serial returns to 1 immediately (async), the frame is abandoned, and no tx_done is generated.
- Width rules:
  - Bit-period counter width = clog2(CLKS_PER_BIT).
  - Bit index counter width = clog2(DATA_W + 1).
  - Both counters wrap to 0 on the terminal count.

Decomposition:
- Shared package: state encoding constants (IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4, 3 bits) and a clog2 helper function.
- One sub-module, bit_timer:
  - Counts 0..CLKS_PER_BIT-1 while enabled.
  - Pulses bit_tick on the terminal count; synchronous clear on frame start.
- The FSM, shift register and parity logic stay in serial_tx.

Test Plan:
- DATA_W = 8, CLKS_PER_BIT = 4, PARITY_EN = 0, send 0xA5 -> tx_serial = 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each held 4 cycles. tx_done pulses at cycle 40 after the handshake; tx_ready low for 40 cycles.
- PARITY_EN = 1, PARITY_ODD = 0, send 0x07 -> parity bit = 1; frame is 44 cycles. PARITY_ODD = 1, send 0x03 -> parity bit = 1.
- tx_valid held high with 0x55 then 0xAA -> second start bit begins exactly 2 cycles after the first tx_done (one idle-high cycle); both frames bit-exact.
- Change tx_data to 0xFF during the DATA state of a 0x00 frame -> all data bits remain 0.
- Assert rst_n = 0 during the DATA state -> tx_serial = 1 with no clock edge; after release, tx_ready = 1, no tx_done, and the next word is sent correctly.
- Idle for 100 cycles with tx_valid = 0 -> tx_serial = 1, tx_busy = 0, tx_done never asserted.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: state encoding and width helper shared by the serial transmitter
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// serial_tx_bit_timer: counts clocks within one serial bit and flags the last one
import serial_tx_pkg::*;

module serial_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic bit_tick
);
    localparam int CW = clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    assign bit_tick = en && cnt == CW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= bit_tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/serial_tx.sv
// serial_tx: start / LSB-first data / optional parity / stop frame transmitter
import serial_tx_pkg::*;

module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);
    localparam int IW = clog2(DATA_W + 1);

    state_t            state, state_n;
    logic [DATA_W-1:0] shift_reg;
    logic [IW-1:0]     bit_idx;
    logic              parity_bit;
    logic              bit_tick;
    logic              accept;
    logic              last_bit;

    assign accept   = tx_valid && tx_ready;
    assign last_bit = bit_idx == IW'(DATA_W - 1);

    serial_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (tx_busy),
        .clr      (tx_ready),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? START : IDLE;
            START:   state_n = bit_tick ? DATA : START;
            DATA:    state_n = (bit_tick && last_bit) ? ((PARITY_EN != 0) ? PARITY : STOP) : DATA;
            PARITY:  state_n = bit_tick ? STOP : PARITY;
            STOP:    state_n = bit_tick ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode registered state only, so inputs never reach the line combinationally
    assign tx_ready  = state == IDLE;
    assign tx_busy   = !tx_ready;
    assign tx_done   = state == STOP && bit_tick;
    assign tx_serial = state == START  ? 1'b0 :
                       state == DATA   ? shift_reg[0] :
                       state == PARITY ? parity_bit : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                shift_reg  <= tx_data;
                parity_bit <= ^tx_data ^ (PARITY_ODD != 0);
                bit_idx    <= '0;
            end else if (state == DATA && bit_tick) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= last_bit ? '0 : bit_idx + 1'b1;
            end
        end
    end
endmodule
